// File: rtl/spi_lcd_seq.sv
// spi_lcd_seq -- SPI LCD front end: power-up reset sequencer, {dc,data} FIFO,
// SPI mode-0 byte shifter with MISO read-back, and post-command delay.
//
// Ports
//   clock, reset        : system clock, synchronous active-high reset
//   dc, in, put, full   : byte write side; a write is taken on every cycle
//                         with put=1 and full=0, otherwise it is dropped
//                         (full is the only back-pressure, no other handshake)
//   hw_reset            : request a new panel reset sequence (acted on in IDLE)
//   ready               : 1 while the sequencer is IDLE
//   out, out_valid      : last byte read on MISO and its one-cycle strobe
//   LCD_reset_n, LCD_clock, LCD_cs_n, LCD_dc, LCD_mosi, LCD_miso : panel pins
module spi_lcd_seq #(
  parameter int FREQ   = 25_000_000,
  parameter int DELAY  = 120,
  parameter int RST_MS = 10,
  parameter int DEPTH  = 4,
  parameter int DIV    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dc,
  input  logic [7:0] in,
  input  logic       put,
  output logic       full,
  input  logic       hw_reset,
  output logic       ready,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       LCD_reset_n,
  output logic       LCD_clock,
  output logic       LCD_cs_n,
  output logic       LCD_dc,
  output logic       LCD_mosi,
  input  logic       LCD_miso
);

  localparam int MS      = FREQ / 1000;
  localparam int RST_CYC = RST_MS * MS;
  localparam int DLY_CYC = DELAY * MS;
  localparam int MAX_CYC = (RST_CYC > DLY_CYC) ? RST_CYC : DLY_CYC;
  localparam int CW      = (MAX_CYC > 0) ? $clog2(MAX_CYC + 1) : 1;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int ENTRIES = 2 ** DEPTH;

  // Counters load N-1 so a wait lasts N cycles; a zero wait still takes one.
  localparam logic [CW-1:0]  RST_LD   = (RST_CYC == 0) ? '0 : CW'(RST_CYC - 1);
  localparam logic [CW-1:0]  DLY_LD   = (DLY_CYC == 0) ? '0 : CW'(DLY_CYC - 1);
  localparam logic [DW-1:0]  DIV_LD   = DW'(DIV - 1);
  localparam logic [DEPTH:0] CNT_FULL = (DEPTH + 1)'(ENTRIES);

  typedef enum logic [2:0] {S_HOLD, S_WAKE, S_IDLE, S_LOAD, S_SHIFT, S_DELAY} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [8:0]       fifo_q [ENTRIES];
  logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH:0]   count_q, count_d;
  logic             full_q, full_d, ready_q, ready_d;
  logic [7:0]       tx_q, tx_d, rx_q, rx_d, out_q, out_d;
  logic [2:0]       bit_q, bit_d;
  logic [DW-1:0]    div_q, div_d;
  logic             out_valid_q, out_valid_d;
  logic             reset_n_q, reset_n_d, sck_q, sck_d, cs_n_q, cs_n_d;
  logic             dc_q, dc_d, mosi_q, mosi_d;
  logic             push, pop, start_load, is_pwr;
  logic [8:0]       head;

  assign head   = fifo_q[rd_ptr_q];
  assign push   = put & ~full_q;   // dropped when full, even if popping now
  assign pop    = (state_q == S_LOAD);
  // SWRESET, SLPIN, SLPOUT need the panel to settle before the next byte.
  assign is_pwr = ~dc_q & ((tx_q == 8'h01) | (tx_q == 8'h10) | (tx_q == 8'h11));

  always_comb begin
    wr_ptr_d = wr_ptr_q + DEPTH'(push);
    rd_ptr_d = rd_ptr_q + DEPTH'(pop);
    count_d  = count_q + (DEPTH + 1)'(push) - (DEPTH + 1)'(pop);
    full_d   = (count_d == CNT_FULL);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bit_d       = bit_q;
    div_d       = div_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    sck_d       = sck_q;
    cs_n_d      = cs_n_q;
    dc_d        = dc_q;
    mosi_d      = mosi_q;
    start_load  = 1'b0;
    case (state_q)
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_WAKE;
          cnt_d   = DLY_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WAKE, S_DELAY: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_IDLE: begin
        if (hw_reset) begin
          state_d = S_HOLD;
          cnt_d   = RST_LD;
        end else if (count_q != '0) begin
          start_load = 1'b1;
        end
      end
      S_LOAD: begin
        tx_d    = head[7:0];
        bit_d   = 3'd7;
        div_d   = DIV_LD;
        sck_d   = 1'b0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_q != '0) begin
          div_d = div_q - DW'(1);
        end else begin
          div_d = DIV_LD;
          if (!sck_q) begin
            // Rising SCK: capture MISO, MSB first.
            sck_d = 1'b1;
            rx_d  = {rx_q[6:0], LCD_miso};
          end else begin
            sck_d = 1'b0;
            if (bit_q == 3'd0) begin
              out_d       = rx_q;
              out_valid_d = 1'b1;
              if (is_pwr) begin
                cs_n_d  = 1'b1;
                state_d = S_DELAY;
                cnt_d   = DLY_LD;
              end else if (count_q != '0) begin
                start_load = 1'b1;   // keep CS low for back-to-back bytes
              end else begin
                cs_n_d  = 1'b1;
                state_d = S_IDLE;
              end
            end else begin
              bit_d  = bit_q - 3'd1;
              mosi_d = tx_q[bit_q - 3'd1];
            end
          end
        end
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = RST_LD;
      end
    endcase
    // Pins for the LOAD cycle are set on the edge entering it from the head.
    if (start_load) begin
      state_d = S_LOAD;
      cs_n_d  = 1'b0;
      dc_d    = head[8];
      mosi_d  = head[7];
    end
  end

  assign reset_n_d = (state_d != S_HOLD);
  assign ready_d   = (state_d == S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_HOLD;
      cnt_q       <= RST_LD;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      ready_q     <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      bit_q       <= '0;
      div_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      reset_n_q   <= 1'b0;
      sck_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      dc_q        <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      ready_q     <= ready_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      reset_n_q   <= reset_n_d;
      sck_q       <= sck_d;
      cs_n_q      <= cs_n_d;
      dc_q        <= dc_d;
      mosi_q      <= mosi_d;
    end
  end

  // Storage only; pointers and count carry the reset state.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= {dc, in};
  end

  assign full        = full_q;
  assign ready       = ready_q;
  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign LCD_reset_n = reset_n_q;
  assign LCD_clock   = sck_q;
  assign LCD_cs_n    = cs_n_q;
  assign LCD_dc      = dc_q;
  assign LCD_mosi    = mosi_q;

endmodule

// File: tb/tb_spi_lcd_seq.sv
// Directed bench for spi_lcd_seq: a DIV=1 instance for most scenarios and a
// DIV=3 instance (held in reset until its own scenario) sharing the byte inputs.
module tb_spi_lcd_seq;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset1, reset3, dc, put, hw_reset;
  logic [7:0] in_b;

  logic       full1, ready1, out_valid1, rstn1, sck1, csn1, dc1, mosi1, miso1;
  logic [7:0] out1;
  logic       full3, ready3, out_valid3, rstn3, sck3, csn3, dc3, mosi3, miso3;
  logic [7:0] out3;

  spi_lcd_seq #(.FREQ(4000), .DELAY(2), .RST_MS(1), .DEPTH(2), .DIV(1)) dut (
    .clock(clock), .reset(reset1), .dc(dc), .in(in_b), .put(put), .full(full1),
    .hw_reset(hw_reset), .ready(ready1), .out(out1), .out_valid(out_valid1),
    .LCD_reset_n(rstn1), .LCD_clock(sck1), .LCD_cs_n(csn1), .LCD_dc(dc1),
    .LCD_mosi(mosi1), .LCD_miso(miso1));

  spi_lcd_seq #(.FREQ(4000), .DELAY(2), .RST_MS(1), .DEPTH(2), .DIV(3)) dut3 (
    .clock(clock), .reset(reset3), .dc(dc), .in(in_b), .put(put), .full(full3),
    .hw_reset(1'b0), .ready(ready3), .out(out3), .out_valid(out_valid3),
    .LCD_reset_n(rstn3), .LCD_clock(sck3), .LCD_cs_n(csn3), .LCD_dc(dc3),
    .LCD_mosi(mosi3), .LCD_miso(miso3));

  // ---------------- MISO slave model ----------------
  logic [7:0] pat1 = 8'h00, pat3 = 8'h00;
  int rise1 = 0, rise3 = 0, base1 = 0, base3 = 0;
  always @(posedge sck1) rise1++;
  always @(posedge sck3) rise3++;

  function automatic logic miso_bit(input logic [7:0] p, input int k);
    if (k >= 0 && k < 8) return p[7-k];
    return 1'b0;
  endfunction

  assign miso1 = miso_bit(pat1, rise1 - base1);
  assign miso3 = miso_bit(pat3, rise3 - base3);

  // ---------------- scoreboard ----------------
  int checks = 0, passes = 0, fails = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic put_byte(input logic d, input logic [7:0] b, input bit expect_tx);
    dc = d; in_b = b; put = 1'b1;
    if (expect_tx) exp_q.push_back({d, b});
    @(negedge clock);
    put = 1'b0;
  endtask

  task automatic wait_cs1(output int n);
    n = 0;
    while (csn1 !== 1'b0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("cs1_low_timeout", csn1, 0);
  endtask

  // Starts at the LOAD cycle, ends at the out_valid cycle.
  task automatic check_byte(input logic [7:0] miso_val, input logic exp_cs_after, input bit hw_mid);
    logic [8:0] e;
    logic [7:0] m;
    int errs;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
    check("load_dc", dc1, e[8]);
    check("load_mosi", mosi1, e[7]);
    check("load_sck", sck1, 0);
    check("load_ready", ready1, 0);
    pat1 = miso_val;
    base1 = rise1;
    errs = 0;
    m = 8'h00;
    for (int s = 0; s < 16; s++) begin
      if (hw_mid && s == 2) hw_reset = 1'b1;
      if (hw_mid && s == 10) hw_reset = 1'b0;
      @(negedge clock);
      if (sck1 !== 1'(s % 2)) errs++;
      if (csn1 !== 1'b0 || rstn1 !== 1'b1) errs++;
      if (s % 2 == 1) m = {m[6:0], mosi1};
    end
    check("shift_shape", errs, 0);
    check("mosi_byte", m, e[7:0]);
    @(negedge clock);
    check("out_valid", out_valid1, 1);
    check("out_byte", out1, miso_val);
    check("sck_after", sck1, 0);
    check("cs_after", csn1, exp_cs_after);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n, errs, first_rstn, first_ready, hi, nr, low;
    logic [7:0] m;
    reset1 = 1'b1; reset3 = 1'b1; put = 1'b0; dc = 1'b0; in_b = 8'h00; hw_reset = 1'b0;
    repeat (3) @(negedge clock);

    // Reset values
    check("rst_reset_n", rstn1, 0);
    check("rst_cs_n", csn1, 1);
    check("rst_sck", sck1, 0);
    check("rst_mosi", mosi1, 0);
    check("rst_dc", dc1, 0);
    check("rst_full", full1, 0);
    check("rst_ready", ready1, 0);
    check("rst_out", out1, 0);
    check("rst_out_valid", out_valid1, 0);

    // Reset release: reset_n high at cycle 4, ready at cycle 12
    reset1 = 1'b0;
    first_rstn = -1; first_ready = -1; errs = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clock);
      if (rstn1 === 1'b1 && first_rstn < 0) first_rstn = i;
      if (ready1 === 1'b1 && first_ready < 0) first_ready = i;
      if (csn1 !== 1'b1) errs++;
    end
    check("rstn_release_cycle", first_rstn, 4);
    check("ready_cycle", first_ready, 12);
    check("cs_high_in_init", errs, 0);

    // Single byte 0xA5, MISO 0x3C
    put_byte(1'b1, 8'hA5, 1'b1);
    wait_cs1(n);
    check("put_to_load", n, 1);
    check_byte(8'h3C, 1'b1, 1'b0);
    @(negedge clock);
    check("out_valid_pulse", out_valid1, 0);

    // Overflow during HOLD, then four back-to-back bytes
    reset1 = 1'b1;
    @(negedge clock);
    reset1 = 1'b0;
    put_byte(1'b1, 8'h2A, 1'b1);
    put_byte(1'b1, 8'h00, 1'b1);
    put_byte(1'b1, 8'h01, 1'b1);
    check("full_after_3", full1, 0);
    put_byte(1'b1, 8'h00, 1'b1);
    check("full_after_4", full1, 1);
    put_byte(1'b1, 8'hEF, 1'b0);
    check("full_after_drop", full1, 1);
    wait_cs1(n);
    check_byte(8'hC3, 1'b0, 1'b0);
    check_byte(8'h5A, 1'b0, 1'b0);
    check_byte(8'hFF, 1'b0, 1'b0);
    check_byte(8'h00, 1'b1, 1'b0);
    errs = 0;
    repeat (20) begin
      @(negedge clock);
      if (csn1 !== 1'b1) errs++;
    end
    check("fifth_byte_dropped", errs, 0);

    // Power command 0x11 then data 0x55: 8 DELAY cycles plus one IDLE cycle
    put_byte(1'b0, 8'h11, 1'b1);
    put_byte(1'b1, 8'h55, 1'b1);
    wait_cs1(n);
    check_byte(8'hA0, 1'b1, 1'b0);
    hi = 0; nr = 0; n = 0;
    while (csn1 === 1'b1 && n < 50) begin
      hi++;
      if (ready1 !== 1'b1) nr++;
      @(negedge clock);
      n++;
    end
    check("pwr_cs_high", hi, 9);
    check("pwr_delay_cycles", nr, 8);
    check_byte(8'h0F, 1'b1, 1'b0);
    // Same value as data: no delay
    put_byte(1'b1, 8'h11, 1'b1);
    put_byte(1'b1, 8'h66, 1'b1);
    wait_cs1(n);
    check_byte(8'h33, 1'b0, 1'b0);
    check_byte(8'hCC, 1'b1, 1'b0);

    // hw_reset in IDLE with two bytes queued
    put_byte(1'b1, 8'h81, 1'b1);
    hw_reset = 1'b1;
    put_byte(1'b1, 8'h7E, 1'b1);
    hw_reset = 1'b0;
    check("hw_hold_rstn", rstn1, 0);
    check("hw_hold_ready", ready1, 0);
    low = 0; n = 0; errs = 0;
    while (rstn1 === 1'b0 && n < 50) begin
      low++;
      if (csn1 !== 1'b1) errs++;
      @(negedge clock);
      n++;
    end
    check("hw_hold_cycles", low, 4);
    check("hw_hold_cs", errs, 0);
    wait_cs1(n);
    check("hw_wake_to_load", n, 9);
    check_byte(8'h96, 1'b0, 1'b1);
    check_byte(8'h69, 1'b1, 1'b0);

    // DIV=3 instance: full byte = 49 cycles
    reset3 = 1'b0;
    n = 0;
    while (ready3 !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("d3_ready_cycle", n, 12);
    put_byte(1'b1, 8'h96, 1'b0);
    n = 0;
    while (csn3 !== 1'b0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("d3_put_to_load", n, 1);
    check("d3_load_dc", dc3, 1);
    check("d3_load_mosi", mosi3, 1);
    check("d3_load_sck", sck3, 0);
    pat3 = 8'h6B;
    base3 = rise3;
    errs = 0; m = 8'h00;
    for (int s = 0; s < 48; s++) begin
      @(negedge clock);
      if (sck3 !== 1'((s / 3) % 2)) errs++;
      if (csn3 !== 1'b0) errs++;
      if (s % 6 == 3) m = {m[6:0], mosi3};
    end
    check("d3_shift_shape", errs, 0);
    check("d3_mosi_byte", m, 8'h96);
    @(negedge clock);
    check("d3_out_valid", out_valid3, 1);
    check("d3_out_byte", out3, 8'h6B);
    check("d3_cs_after", csn3, 1);

    // DIV=3 mid-byte reset with a second byte queued
    put_byte(1'b1, 8'hE1, 1'b0);
    put_byte(1'b1, 8'h1E, 1'b0);
    check("d3_load2_cs", csn3, 0);
    errs = 0;
    for (int s = 0; s < 25; s++) begin
      @(negedge clock);
      if (sck3 !== 1'((s / 3) % 2)) errs++;
    end
    check("d3_shift2_shape", errs, 0);
    reset3 = 1'b1;
    @(negedge clock);
    check("d3_abort_cs", csn3, 1);
    check("d3_abort_rstn", rstn3, 0);
    check("d3_abort_full", full3, 0);
    check("d3_abort_ready", ready3, 0);
    check("d3_abort_sck", sck3, 0);
    reset3 = 1'b0;
    n = 0;
    while (ready3 !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("d3_rerun_ready", n, 12);
    errs = 0;
    repeat (20) begin
      @(negedge clock);
      if (csn3 !== 1'b1) errs++;
    end
    check("d3_fifo_flushed", errs, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
